// File: rtl/row_sweep_arbiter.sv
// -----------------------------------------------------------------------------
// row_sweep_arbiter
//
// Row arbiter for the pixel-block readout hierarchy. When idle it captures the
// active row requests as a group. It then hands rows one at a time to the
// column stage as a registered one-hot grant plus a registered binary row
// address. When the group is exhausted it pulses a one-cycle group release.
//
// Two service modes are latched at group start:
//   mode 0 (sweep)       : each captured row is served at most once, lowest
//                          index first. Rows that dropped their request are
//                          skipped. Rows that arrive after the capture wait
//                          for the next group.
//   mode 1 (round-robin) : live requests are served. Priority rotates to the
//                          first requesting row strictly above the last
//                          granted row, wrapping through 0.
//
// Handshake: gnt_o/xadd_o are offered while gnt_valid_o is high. They stay
// stable until a cycle in which gnt_valid_o and gnt_ready_i are both high.
// That cycle completes the transfer, and the next grant, if any, is loaded on
// the same edge.
//
// Control priority: reset_i > refresh_i > enable_i. With enable_i low, every
// register holds and gnt_ready_i is ignored.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   enable_i       advance enable; low freezes state and outputs
//   refresh_i      synchronous abort of the current group (no release pulse)
//   mode_i         0 = sweep, 1 = round-robin; sampled at group start
//   req_i          row requests
//   gnt_ready_i    downstream finished the granted row
//   gnt_o          registered one-hot grant
//   xadd_o         registered index of gnt_o (0 when no grant)
//   gnt_valid_o    grant valid
//   grp_release_o  group-completion pulse
//   busy_o         high whenever the arbiter is not idle
//   served_cnt_o   handshakes completed in the current or last group
//   dbg_state_o    current FSM state (debug)
// -----------------------------------------------------------------------------
module row_sweep_arbiter #(
   parameter int Lvl_ROWS    = 8,
   parameter int Lvl_ROW_ADD = 3
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   enable_i,
   input  logic                   refresh_i,
   input  logic                   mode_i,
   input  logic [Lvl_ROWS-1:0]    req_i,
   input  logic                   gnt_ready_i,
   output logic [Lvl_ROWS-1:0]    gnt_o,
   output logic [Lvl_ROW_ADD-1:0] xadd_o,
   output logic                   gnt_valid_o,
   output logic                   grp_release_o,
   output logic                   busy_o,
   output logic [Lvl_ROW_ADD:0]   served_cnt_o,
   output logic [1:0]             dbg_state_o
);

   localparam int CNT_W = Lvl_ROW_ADD + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(Lvl_ROWS);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SERVE   = 2'd1,
      S_RELEASE = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   mode_q, mode_d;
   logic [Lvl_ROWS-1:0]    pend_q, pend_d;
   logic [Lvl_ROWS-1:0]    gnt_q, gnt_d;
   logic [Lvl_ROW_ADD-1:0] xadd_q, xadd_d;
   logic                   valid_q, valid_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;

   // Index -> one-hot row vector.
   function automatic logic [Lvl_ROWS-1:0] row_onehot(input logic [Lvl_ROW_ADD-1:0] idx);
      logic [Lvl_ROWS-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   // Lowest set bit. Result is {found, index}.
   function automatic logic [Lvl_ROW_ADD:0] find_lowest(input logic [Lvl_ROWS-1:0] vec);
      logic                   found;
      logic [Lvl_ROW_ADD-1:0] idx;
      logic [Lvl_ROW_ADD-1:0] pos;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < Lvl_ROWS; i++) begin
         pos = Lvl_ROW_ADD'(i);
         if (!found && vec[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
      return {found, idx};
   endfunction

   // First set bit strictly above 'last', wrapping through 0. 'last' itself
   // is checked at the end of the scan. Result is {found, index}.
   function automatic logic [Lvl_ROW_ADD:0] find_after(input logic [Lvl_ROWS-1:0]    vec,
                                                      input logic [Lvl_ROW_ADD-1:0] last);
      logic                   found;
      logic [Lvl_ROW_ADD-1:0] idx;
      logic [Lvl_ROW_ADD-1:0] pos;
      int                     p;
      found = 1'b0;
      idx   = '0;
      for (int k = 1; k <= Lvl_ROWS; k++) begin
         p   = (int'(last) + k) % Lvl_ROWS;
         pos = Lvl_ROW_ADD'(p);
         if (!found && vec[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
      return {found, idx};
   endfunction

   logic [Lvl_ROW_ADD:0]   start_sel;
   logic [Lvl_ROW_ADD:0]   sweep_sel;
   logic [Lvl_ROW_ADD:0]   rr_sel;
   logic [Lvl_ROW_ADD:0]   next_sel;
   logic                   handshake;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      pend_d    = pend_q;
      gnt_d     = gnt_q;
      xadd_d    = xadd_q;
      valid_d   = valid_q;
      cnt_d     = cnt_q;

      start_sel = find_lowest(req_i);
      // Sweep candidates: captured rows that are still requesting.
      sweep_sel = find_lowest(pend_q & req_i);
      rr_sel    = find_after(req_i, xadd_q);
      next_sel  = mode_q ? rr_sel : sweep_sel;
      handshake = valid_q & gnt_ready_i;

      if (refresh_i) begin
         state_d = S_IDLE;
         pend_d  = '0;
         gnt_d   = '0;
         xadd_d  = '0;
         valid_d = 1'b0;
         cnt_d   = '0;
      end else if (enable_i) begin
         case (state_q)
            S_IDLE: begin
               if (start_sel[Lvl_ROW_ADD]) begin
                  mode_d  = mode_i;
                  pend_d  = req_i & ~row_onehot(start_sel[Lvl_ROW_ADD-1:0]);
                  gnt_d   = row_onehot(start_sel[Lvl_ROW_ADD-1:0]);
                  xadd_d  = start_sel[Lvl_ROW_ADD-1:0];
                  valid_d = 1'b1;
                  cnt_d   = '0;
                  state_d = S_SERVE;
               end
            end
            S_SERVE: begin
               if (handshake) begin
                  if (cnt_q != CNT_MAX) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
                  if (next_sel[Lvl_ROW_ADD]) begin
                     gnt_d  = row_onehot(next_sel[Lvl_ROW_ADD-1:0]);
                     xadd_d = next_sel[Lvl_ROW_ADD-1:0];
                     // Only the sweep consumes its snapshot.
                     if (!mode_q) begin
                        pend_d = pend_q & ~row_onehot(next_sel[Lvl_ROW_ADD-1:0]);
                     end
                  end else begin
                     gnt_d   = '0;
                     xadd_d  = '0;
                     valid_d = 1'b0;
                     state_d = S_RELEASE;
                  end
               end
            end
            S_RELEASE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         pend_q  <= '0;
         gnt_q   <= '0;
         xadd_q  <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         pend_q  <= pend_d;
         gnt_q   <= gnt_d;
         xadd_q  <= xadd_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt_o         = gnt_q;
   assign xadd_o        = xadd_q;
   assign gnt_valid_o   = valid_q;
   assign grp_release_o = (state_q == S_RELEASE);
   assign busy_o        = (state_q != S_IDLE);
   assign served_cnt_o  = cnt_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_row_sweep_arbiter.sv
// -----------------------------------------------------------------------------
// tb_row_sweep_arbiter
//
// Directed scenarios followed by a randomized run. A group-level reference
// model predicts every output after each clock edge. The model represents the
// sweep snapshot as an ordered list of row indices and finds the round-robin
// successor with modular arithmetic.
// -----------------------------------------------------------------------------
module tb_row_sweep_arbiter;

   localparam int ROWS = 8;
   localparam int ADD  = 3;

   // ---------------- clock / reset block ----------------
   logic            clk = 1'b0;
   always #5 clk = ~clk;

   logic            reset_i;
   logic            enable_i;
   logic            refresh_i;
   logic            mode_i;
   logic [ROWS-1:0] req_i;
   logic            gnt_ready_i;
   logic [ROWS-1:0] gnt_o;
   logic [ADD-1:0]  xadd_o;
   logic            gnt_valid_o;
   logic            grp_release_o;
   logic            busy_o;
   logic [ADD:0]    served_cnt_o;
   logic [1:0]      dbg_state_o;

   row_sweep_arbiter #(.Lvl_ROWS(ROWS), .Lvl_ROW_ADD(ADD)) dut (
      .clk_i        (clk),
      .reset_i      (reset_i),
      .enable_i     (enable_i),
      .refresh_i    (refresh_i),
      .mode_i       (mode_i),
      .req_i        (req_i),
      .gnt_ready_i  (gnt_ready_i),
      .gnt_o        (gnt_o),
      .xadd_o       (xadd_o),
      .gnt_valid_o  (gnt_valid_o),
      .grp_release_o(grp_release_o),
      .busy_o       (busy_o),
      .served_cnt_o (served_cnt_o),
      .dbg_state_o  (dbg_state_o)
   );

   // ---------------- reference model state ----------------
   bit m_busy;
   bit m_rel;
   bit m_valid;
   int m_gidx;
   int m_cnt;
   bit m_mode;
   int m_pend[$];

   int n_chk  = 0;
   int n_pass = 0;

   function automatic bit row_bit(input logic [ROWS-1:0] v, input int p);
      logic [ROWS-1:0] t;
      t = v >> p;
      return t[0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_clear();
      m_busy  = 0;
      m_rel   = 0;
      m_valid = 0;
      m_gidx  = 0;
      m_cnt   = 0;
      m_pend.delete();
   endtask

   // Group-level behaviour for one clock edge with the given inputs.
   task automatic model_step(input bit rst, input bit rf, input bit en, input bit md,
                             input logic [ROWS-1:0] rq, input bit rdy);
      bit found;
      int nxt;
      int low;
      if (rst) begin
         model_clear();
         m_mode = 0;
      end else if (rf) begin
         model_clear();
      end else if (en) begin
         if (!m_busy) begin
            if (rq != 0) begin
               low = -1;
               for (int i = 0; i < ROWS; i++) if (low < 0 && row_bit(rq, i)) low = i;
               m_pend.delete();
               for (int i = low + 1; i < ROWS; i++) if (row_bit(rq, i)) m_pend.push_back(i);
               m_mode  = md;
               m_gidx  = low;
               m_valid = 1;
               m_busy  = 1;
               m_cnt   = 0;
            end
         end else if (m_rel) begin
            m_rel  = 0;
            m_busy = 0;
         end else if (rdy) begin
            if (m_cnt < ROWS) m_cnt++;
            found = 0;
            nxt   = 0;
            if (m_mode) begin
               for (int k = 1; k <= ROWS; k++) begin
                  if (!found && row_bit(rq, (m_gidx + k) % ROWS)) begin
                     found = 1;
                     nxt   = (m_gidx + k) % ROWS;
                  end
               end
            end else begin
               for (int j = 0; j < m_pend.size(); j++) begin
                  if (!found && row_bit(rq, m_pend[j])) begin
                     found = 1;
                     nxt   = m_pend[j];
                     m_pend.delete(j);
                  end
               end
            end
            if (found) begin
               m_gidx = nxt;
            end else begin
               m_valid = 0;
               m_gidx  = 0;
               m_rel   = 1;
            end
         end
      end
   endtask

   // ---------------- driver task ----------------
   // Drive inputs, advance the model, clock once, and compare all outputs 1ns
   // after the edge.
   task automatic cyc(input bit rst, input bit rf, input bit en, input bit md,
                      input logic [ROWS-1:0] rq, input bit rdy);
      logic [ROWS-1:0] exp_gnt;
      reset_i     = rst;
      refresh_i   = rf;
      enable_i    = en;
      mode_i      = md;
      req_i       = rq;
      gnt_ready_i = rdy;
      model_step(rst, rf, en, md, rq, rdy);
      @(posedge clk);
      #1;
      exp_gnt = m_valid ? (ROWS'(1) << m_gidx) : '0;
      check("gnt",     32'(gnt_o),         32'(exp_gnt));
      check("xadd",    32'(xadd_o),        m_valid ? 32'(m_gidx) : 32'd0);
      check("valid",   32'(gnt_valid_o),   32'(m_valid));
      check("release", 32'(grp_release_o), 32'(m_rel));
      check("busy",    32'(busy_o),        32'(m_busy));
      check("cnt",     32'(served_cnt_o),  32'(m_cnt));
   endtask

   logic [ROWS-1:0] r_req;
   bit              r_md;

   initial begin
      reset_i     = 1'b1;
      refresh_i   = 1'b0;
      enable_i    = 1'b1;
      mode_i      = 1'b0;
      req_i       = '0;
      gnt_ready_i = 1'b0;
      model_clear();
      m_mode = 0;

      // Reset state
      cyc(1, 0, 1, 0, 8'h00, 0);
      cyc(1, 0, 1, 0, 8'hFF, 1);
      check("rst_gnt", 32'(gnt_o), 32'h0);
      check("rst_busy", 32'(busy_o), 32'h0);

      // Sweep, req=1010_0100, ready high
      cyc(0, 0, 1, 0, 8'hA4, 1);
      check("tp1_g0", 32'(gnt_o), 32'h04);
      check("tp1_x0", 32'(xadd_o), 32'd2);
      cyc(0, 0, 1, 0, 8'hA4, 1);
      check("tp1_g1", 32'(gnt_o), 32'h20);
      cyc(0, 0, 1, 0, 8'hA4, 1);
      check("tp1_x2", 32'(xadd_o), 32'd7);
      cyc(0, 0, 1, 0, 8'h00, 1);
      check("tp1_rel", 32'(grp_release_o), 32'd1);
      check("tp1_cnt", 32'(served_cnt_o), 32'd3);
      cyc(0, 0, 1, 0, 8'h00, 1);
      check("tp1_idle_rel", 32'(grp_release_o), 32'd0);

      // Sweep with backpressure and a dropped row
      cyc(0, 0, 1, 0, 8'h0B, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0, 8'h0B, 0);
         check("tp2_hold", 32'(gnt_o), 32'h01);
      end
      cyc(0, 0, 1, 0, 8'h02, 1);
      check("tp2_g1", 32'(gnt_o), 32'h02);
      cyc(0, 0, 1, 0, 8'h02, 1);
      check("tp2_rel", 32'(grp_release_o), 32'd1);
      check("tp2_cnt", 32'(served_cnt_o), 32'd2);
      cyc(0, 0, 1, 0, 8'h00, 0);

      // Round-robin between rows 0 and 7, then drain
      cyc(0, 0, 1, 1, 8'h81, 1);
      check("tp3_g0", 32'(xadd_o), 32'd0);
      cyc(0, 0, 1, 0, 8'h81, 1);
      check("tp3_g7", 32'(xadd_o), 32'd7);
      cyc(0, 0, 1, 0, 8'h81, 1);
      check("tp3_g0b", 32'(xadd_o), 32'd0);
      cyc(0, 0, 1, 0, 8'h81, 1);
      check("tp3_g7b", 32'(xadd_o), 32'd7);
      cyc(0, 0, 1, 0, 8'h00, 1);
      check("tp3_rel", 32'(grp_release_o), 32'd1);
      cyc(0, 0, 1, 0, 8'h00, 1);

      // Refresh while row 5 is granted
      cyc(0, 0, 1, 0, 8'h20, 0);
      check("tp4_g5", 32'(gnt_o), 32'h20);
      cyc(0, 1, 1, 0, 8'h20, 1);
      check("tp4_busy", 32'(busy_o), 32'd0);
      check("tp4_cnt", 32'(served_cnt_o), 32'd0);
      cyc(0, 0, 1, 0, 8'h00, 1);
      check("tp4_norel", 32'(grp_release_o), 32'd0);

      // Enable low during SERVE with ready high
      cyc(0, 0, 1, 0, 8'hF0, 1);
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 0, 0, 8'hF0, 1);
         check("tp5_frz", 32'(xadd_o), 32'd4);
      end
      cyc(0, 0, 1, 0, 8'hF0, 1);
      check("tp5_resume", 32'(xadd_o), 32'd5);

      // Reset mid-group, then a new group
      cyc(1, 0, 1, 0, 8'hF0, 1);
      check("tp6_rst_valid", 32'(gnt_valid_o), 32'd0);
      cyc(0, 0, 1, 0, 8'h40, 0);
      check("tp6_g6", 32'(gnt_o), 32'h40);
      check("tp6_x6", 32'(xadd_o), 32'd6);
      cyc(0, 1, 1, 0, 8'h00, 0);

      // Randomized run
      r_req = 8'h00;
      r_md  = 0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            r_req = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         end
         r_md = ($urandom_range(0, 1) == 1);
         cyc($urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 7) != 0, r_md, r_req, $urandom_range(0, 2) != 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/row_sweep_arbiter.md
# row_sweep_arbiter

Parametrised next-generation row arbiter for the pixel-block readout hierarchy. It snapshots a group of active row requests, issues one-hot row grants with a binary row address under a valid/ready handshake to the downstream column stage, and pulses a group-release when the group is exhausted. It supports two modes: a snapshot sweep (each captured row served once, lowest index first) and a live round-robin mode that rotates priority past the last served row.

## Interface
Parameters:
- Lvl_ROWS, 8, number of row request lines (≥2)
- Lvl_ROW_ADD, 3, row address width; must equal $clog2(Lvl_ROWS)

Ports:
- clk_i  input  1  clock; all logic on rising edge
- reset_i  input  1  synchronous, active-high reset
- enable_i  input  1  advance enable; low freezes all state and outputs
- refresh_i  input  1  synchronous abort of the current group
- mode_i  input  1  0 = snapshot sweep, 1 = live round-robin; sampled at group start
- req_i  input  Lvl_ROWS  active row requests
- gnt_ready_i  input  1  downstream has finished the granted row
- gnt_o  output  Lvl_ROWS  registered one-hot grant
- xadd_o  output  Lvl_ROW_ADD  registered binary index of gnt_o; 0 when no grant
- gnt_valid_o  output  1  gnt_o/xadd_o valid
- grp_release_o  output  1  one-cycle pulse at group completion
- busy_o  output  1  high whenever state ≠ IDLE
- served_cnt_o  output  Lvl_ROW_ADD+1  handshakes completed in the current or last group

## Operation
- Priority: reset_i > refresh_i > enable_i. With enable_i=0 and neither reset_i nor refresh_i asserted, state, pend_ff, counter and all outputs hold, and gnt_ready_i is ignored.
- States: IDLE, SERVE, RELEASE.
- IDLE: gnt_o=0, gnt_valid_o=0. If |req_i: mode_ff<=mode_i; pend_ff<=req_i with the selected bit cleared; grant the lowest set bit of req_i; served_cnt_o<=0; go to SERVE.
- SERVE: gnt_o, xadd_o and gnt_valid_o are held until handshake (gnt_valid_o & gnt_ready_i). The grant is held even if the granted row drops its request.
- On handshake, served_cnt_o increments (saturating at Lvl_ROWS), and the next row is chosen as follows:
  - Sweep (mode_ff=0): candidates are pend_ff & req_i, so rows that dropped their request are skipped. Grant the lowest set candidate and clear it from pend_ff. Rows not in the snapshot are ignored until the next group.
  - Round-robin (mode_ff=1): candidates are the live req_i. Grant the first set bit strictly above the last granted index, wrapping through 0. The last granted row is considered last.
  - If there is no candidate: gnt_o<=0, xadd_o<=0, gnt_valid_o<=0, and go to RELEASE.
- RELEASE: grp_release_o=1 for exactly one cycle, then IDLE. A new group cannot start in the RELEASE cycle.
- refresh_i (any state): gnt_o<=0, xadd_o<=0, gnt_valid_o<=0, pend_ff<=0, served_cnt_o<=0, go to IDLE. No release pulse is generated.
- reset_i: same as refresh_i, plus mode_ff<=0.
- Address encoding: xadd_o is the index of the single set bit of gnt_o. It is registered together with gnt_o and is never decoded combinationally from gnt_o.

## Timing
- Reset values: gnt_o=0, xadd_o=0, gnt_valid_o=0, grp_release_o=0, busy_o=0, served_cnt_o=0.
- Start latency: req_i sampled in IDLE at edge N; the grant is visible after edge N (1 cycle).
- Back-to-back grants: a handshake at edge k and the next grant are on the same edge, so there is no bubble. With gnt_ready_i tied high there is 1 grant per cycle.
- Release: on the final handshake at edge k, gnt_valid_o=0 and grp_release_o=1 after edge k. IDLE follows after edge k+1. The earliest next grant appears after edge k+2.
- Simultaneous refresh_i and handshake: refresh wins, and served_cnt_o is cleared.
- A grant change on gnt_o without a handshake is forbidden; verification checks this.
- gnt_o is always one-hot or zero, and gnt_valid_o == |gnt_o.

## Test plan
- Sweep, enable=1, ready=1, req=8'b1010_0100 held → gnt 0x04/x=2, 0x20/x=5, 0x80/x=7 on consecutive cycles; then a one-cycle grp_release_o; served_cnt_o=3.
- Sweep with backpressure/drop: req=8'b0000_1011; ready low 3 cycles → gnt 0x01 held unchanged; set req=8'b0000_0010 and raise ready → gnt 0x02; at the next handshake, release (row 3 skipped); served_cnt_o=2.
- Round-robin: mode=1, req=8'b1000_0001, ready=1 → grants 0,7,0,7…, with no release. Set req=0 during the row-7 grant → release pulse, then IDLE.
- Refresh mid-SERVE (row 5 granted), refresh_i with ready=1 → next cycle gnt_o=0, gnt_valid_o=0, busy_o=0, served_cnt_o=0, and grp_release_o is never asserted.
- enable_i low for 4 cycles during SERVE with ready=1 → gnt_o, xadd_o and served_cnt_o frozen. Restoring enable_i → grants resume.
- reset_i asserted mid-group → all outputs reach their reset values after the next edge. After deassertion with req=8'b0100_0000 → gnt 0x40/x=6 one cycle later.
